// File: rtl/cnt_share_arbiter.sv
// ---------------------------------------------------------------------------
// cnt_share_arbiter
//
// Round-robin arbiter that time-shares one up-counter among NREQ requesters.
// A granted requester owns the counter for (terminal count + 1) cycles and
// then receives a one-cycle done pulse. A requester that withdraws while it
// holds the counter aborts the run; it gets no done pulse.
//
// Handshake (req/grant): req[i] is a level. It is raised to ask for the
// counter and held for the whole ownership. grant[i] answers it, and
// done[i] marks normal completion. The requester drops req[i] on done[i].
// Dropping req[i] while grant[i] is high is an abort.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   req       in   [NREQ]     request levels
//   load_val  in   [NREQ*CW]  terminal count, slice i = [i*CW +: CW]
//   grant     out  [NREQ]     one-hot owner, zero when idle
//   busy      out             OR of grant
//   cnt       out  [CW]       shared counter value
//   done      out  [NREQ]     one-cycle normal-expiry pulse
//   state_dbg out             1 while the FSM is in RUN
// ---------------------------------------------------------------------------
module cnt_share_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] load_val,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [CW-1:0]      cnt,
  output logic [NREQ-1:0]    done,
  output logic               state_dbg
);

  localparam int RW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW1 = RW + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q,  done_d;
  logic            busy_q,  busy_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [CW-1:0]   tc_q,    tc_d;
  logic [RW-1:0]   rr_q,    rr_d;
  logic [RW-1:0]   gidx_q,  gidx_d;

  // Round-robin pick: first set req bit at or above rr_q, wrapping at NREQ.
  // The scan index is kept one bit wider so the wrap works for any NREQ,
  // not just powers of two.
  logic            pick_vld;
  logic [RW-1:0]   pick_idx;
  logic [RW-1:0]   pick_nxt;
  logic [RW1-1:0]  scan_idx;
  logic [CW-1:0]   pick_tc;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_q} + RW1'(k);
      if (scan_idx >= RW1'(NREQ)) begin
        scan_idx = scan_idx - RW1'(NREQ);
      end
      if (!pick_vld && req[scan_idx[RW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx[RW-1:0];
      end
    end
    pick_nxt = (pick_idx == RW'(NREQ - 1)) ? '0 : pick_idx + RW'(1);
    pick_tc  = load_val[pick_idx*CW +: CW];
  end

  // Next-state and registered outputs.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    tc_d    = tc_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d           = RUN;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          cnt_d             = '0;
          tc_d              = pick_tc;
          rr_d              = pick_nxt;
          gidx_d            = pick_idx;
        end
      end
      RUN: begin
        if (!req[gidx_q]) begin
          // Withdrawal beats expiry: counter is cleared, no done pulse.
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == tc_q) begin
          // Normal expiry: counter keeps the terminal value.
          state_d        = IDLE;
          grant_d        = '0;
          done_d[gidx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      tc_q    <= '0;
      rr_q    <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign cnt       = cnt_q;
  assign state_dbg = (state_q == RUN);

endmodule

// File: tb/tb_cnt_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cnt_share_arbiter
//
// Directed scenarios with fixed expected tables, then a randomized run
// checked cycle by cycle against an integer reference model of the
// arbitration rules, plus a grant-order scoreboard.
// ---------------------------------------------------------------------------
module tb_cnt_share_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 8;
  localparam int VW   = 2*NREQ + CW + 1;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] load_val;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic [CW-1:0]      cnt;
  logic [NREQ-1:0]    done;
  logic               state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  cnt_share_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .load_val(load_val),
    .grant(grant),
    .busy(busy),
    .cnt(cnt),
    .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000ns, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req   = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Expected output vector {grant, busy, cnt, done}; busy is the OR of grant.
  function automatic logic [VW-1:0] pack(input logic [NREQ-1:0] g,
                                         input logic [CW-1:0]   c,
                                         input logic [NREQ-1:0] d);
    return {g, |g, c, d};
  endfunction

  function automatic string vec_str(input logic [VW-1:0] v);
    return $sformatf("g=%b b=%b c=%0d d=%b", v[VW-1 -: NREQ], v[NREQ+CW],
                     v[NREQ+CW-1 -: CW], v[NREQ-1:0]);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; req = '0; load_val = '0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({grant, busy, cnt, done} !== pack('0, '0, '0)) begin
      n_errors++;
      $display("FAIL reset_async: got %s want %s", vec_str({grant, busy, cnt, done}), vec_str(pack('0, '0, '0)));
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({grant, busy, cnt, done} !== pack('0, '0, '0)) begin
      n_errors++;
      $display("FAIL reset_idle: got %s want %s", vec_str({grant, busy, cnt, done}), vec_str(pack('0, '0, '0)));
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] rq_q[$];
    logic [VW-1:0]   exp_q[$];
    apply_reset();
    load_val = '0;
    load_val[0 +: CW] = CW'(3);
    for (int i = 0; i <= 3; i++) begin
      rq_q.push_back(4'b0001); exp_q.push_back(pack(4'b0001, CW'(i), '0));
    end
    rq_q.push_back(4'b0001); exp_q.push_back(pack('0, CW'(3), 4'b0001));
    rq_q.push_back(4'b0000); exp_q.push_back(pack('0, CW'(3), '0));
    for (int i = 0; i < exp_q.size(); i++) begin
      req = rq_q[i];
      tick();
      n_checks++;
      if ({grant, busy, cnt, done} !== exp_q[i]) begin
        n_errors++;
        $display("FAIL single step%0d: got %s want %s", i, vec_str({grant, busy, cnt, done}), vec_str(exp_q[i]));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] g;
    logic [VW-1:0]   exp_q[$];
    apply_reset();
    for (int i = 0; i < NREQ; i++) load_val[i*CW +: CW] = CW'(1);
    for (int n = 0; n < 5; n++) begin
      g = NREQ'(1) << (n % NREQ);
      exp_q.push_back(pack(g, CW'(0), '0));
      exp_q.push_back(pack(g, CW'(1), '0));
      exp_q.push_back(pack('0, CW'(1), g));
    end
    exp_q.push_back(pack('0, CW'(1), '0));
    for (int i = 0; i < exp_q.size(); i++) begin
      req = (i == exp_q.size() - 1) ? 4'b0000 : 4'b1111;
      tick();
      n_checks++;
      if ({grant, busy, cnt, done} !== exp_q[i]) begin
        n_errors++;
        $display("FAIL round_robin step%0d: got %s want %s", i, vec_str({grant, busy, cnt, done}), vec_str(exp_q[i]));
      end
    end
  endtask

  task automatic test_rr_wrap();
    logic [NREQ-1:0] rq_q[$];
    logic [VW-1:0]   exp_q[$];
    apply_reset();
    load_val = '0;
    rq_q.push_back(4'b1000); exp_q.push_back(pack(4'b1000, '0, '0));
    rq_q.push_back(4'b1000); exp_q.push_back(pack('0, '0, 4'b1000));
    rq_q.push_back(4'b1001); exp_q.push_back(pack(4'b0001, '0, '0));
    rq_q.push_back(4'b1001); exp_q.push_back(pack('0, '0, 4'b0001));
    rq_q.push_back(4'b1001); exp_q.push_back(pack(4'b1000, '0, '0));
    rq_q.push_back(4'b1001); exp_q.push_back(pack('0, '0, 4'b1000));
    rq_q.push_back(4'b0000); exp_q.push_back(pack('0, '0, '0));
    for (int i = 0; i < exp_q.size(); i++) begin
      req = rq_q[i];
      tick();
      n_checks++;
      if ({grant, busy, cnt, done} !== exp_q[i]) begin
        n_errors++;
        $display("FAIL rr_wrap step%0d: got %s want %s", i, vec_str({grant, busy, cnt, done}), vec_str(exp_q[i]));
      end
    end
  endtask

  task automatic test_abort();
    logic [NREQ-1:0] rq_q[$];
    logic [VW-1:0]   exp_q[$];
    apply_reset();
    load_val = '0;
    load_val[0*CW +: CW] = CW'(10);
    load_val[1*CW +: CW] = CW'(2);
    for (int i = 0; i <= 4; i++) begin
      rq_q.push_back(4'b0011); exp_q.push_back(pack(4'b0001, CW'(i), '0));
    end
    rq_q.push_back(4'b0010); exp_q.push_back(pack('0, '0, '0));
    for (int i = 0; i <= 2; i++) begin
      rq_q.push_back(4'b0010); exp_q.push_back(pack(4'b0010, CW'(i), '0));
    end
    rq_q.push_back(4'b0010); exp_q.push_back(pack('0, CW'(2), 4'b0010));
    rq_q.push_back(4'b0000); exp_q.push_back(pack('0, CW'(2), '0));
    for (int i = 0; i < exp_q.size(); i++) begin
      req = rq_q[i];
      tick();
      n_checks++;
      if ({grant, busy, cnt, done} !== exp_q[i]) begin
        n_errors++;
        $display("FAIL abort step%0d: got %s want %s", i, vec_str({grant, busy, cnt, done}), vec_str(exp_q[i]));
      end
    end
  endtask

  task automatic test_tc_boundary();
    logic [NREQ-1:0] rq_q[$];
    logic [VW-1:0]   exp_q[$];
    apply_reset();
    load_val = '0;
    // tc = 0 on requester 2
    rq_q.push_back(4'b0100); exp_q.push_back(pack(4'b0100, '0, '0));
    rq_q.push_back(4'b0100); exp_q.push_back(pack('0, '0, 4'b0100));
    rq_q.push_back(4'b0000); exp_q.push_back(pack('0, '0, '0));
    // tc = all ones on requester 0
    for (int i = 0; i <= 255; i++) begin
      rq_q.push_back(4'b0001); exp_q.push_back(pack(4'b0001, CW'(i), '0));
    end
    rq_q.push_back(4'b0001); exp_q.push_back(pack('0, CW'(255), 4'b0001));
    rq_q.push_back(4'b0000); exp_q.push_back(pack('0, CW'(255), '0));
    rq_q.push_back(4'b0000); exp_q.push_back(pack('0, CW'(255), '0));
    for (int i = 0; i < exp_q.size(); i++) begin
      req = rq_q[i];
      if (i == 3) load_val[0 +: CW] = CW'(255);
      if (i == 20) load_val[0 +: CW] = CW'(5);   // change mid-run must be ignored
      tick();
      n_checks++;
      if ({grant, busy, cnt, done} !== exp_q[i]) begin
        n_errors++;
        $display("FAIL tc_boundary step%0d: got %s want %s", i, vec_str({grant, busy, cnt, done}), vec_str(exp_q[i]));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [NREQ-1:0] rq_q[$];
    logic [VW-1:0]   exp_q[$];
    apply_reset();
    load_val = '0;
    load_val[1*CW +: CW] = CW'(20);
    rq_q.push_back(4'b0001); exp_q.push_back(pack(4'b0001, '0, '0));
    rq_q.push_back(4'b0001); exp_q.push_back(pack('0, '0, 4'b0001));
    for (int i = 0; i <= 5; i++) begin
      rq_q.push_back(4'b0010); exp_q.push_back(pack(4'b0010, CW'(i), '0));
    end
    // after release with all requesting: pointer is back at 0
    rq_q.push_back(4'b1111); exp_q.push_back(pack(4'b0001, '0, '0));
    rq_q.push_back(4'b1111); exp_q.push_back(pack('0, '0, 4'b0001));
    rq_q.push_back(4'b0000); exp_q.push_back(pack('0, '0, '0));
    for (int i = 0; i < exp_q.size(); i++) begin
      req = rq_q[i];
      if (i == 8) begin
        // mid-cycle reset while cnt = 5, held across one edge
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({grant, busy, cnt, done} !== pack('0, '0, '0)) begin
          n_errors++;
          $display("FAIL async_reset_now: got %s want %s", vec_str({grant, busy, cnt, done}), vec_str(pack('0, '0, '0)));
        end
        tick();
        n_checks++;
        if ({grant, busy, cnt, done} !== pack('0, '0, '0)) begin
          n_errors++;
          $display("FAIL async_reset_held: got %s want %s", vec_str({grant, busy, cnt, done}), vec_str(pack('0, '0, '0)));
        end
        reset = 1'b1;
      end
      tick();
      n_checks++;
      if ({grant, busy, cnt, done} !== exp_q[i]) begin
        n_errors++;
        $display("FAIL async_reset step%0d: got %s want %s", i, vec_str({grant, busy, cnt, done}), vec_str(exp_q[i]));
      end
    end
  endtask

  // Randomized requesters against an integer model of the rules:
  // owner = -1 when idle; ptr = next requester with top priority.
  task automatic test_random();
    int owner, mcnt, mtc, ptr, mdone;
    logic [NREQ-1:0] eg, ed, prev_grant, g0;
    logic [VW-1:0]   expv;
    logic [NREQ-1:0] exp_q[$];
    apply_reset();
    owner = -1; mcnt = 0; mtc = 0; ptr = 0; mdone = -1; prev_grant = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (i == mdone) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (i == owner) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if ($urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
        load_val[i*CW +: CW] = ($urandom_range(0, 7) == 0) ? CW'($urandom) : CW'($urandom_range(0, 5));
      end
      mdone = -1;
      if (owner < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (owner < 0 && req[(ptr + k) % NREQ]) begin
            owner = (ptr + k) % NREQ;
            mcnt  = 0;
            mtc   = int'(load_val[owner*CW +: CW]);
            ptr   = (owner + 1) % NREQ;
            exp_q.push_back(NREQ'(1) << owner);
          end
        end
      end else if (!req[owner]) begin
        owner = -1;
        mcnt  = 0;
      end else if (mcnt == mtc) begin
        mdone = owner;
        owner = -1;
      end else begin
        mcnt++;
      end
      tick();
      eg   = (owner >= 0) ? (NREQ'(1) << owner) : '0;
      ed   = (mdone >= 0) ? (NREQ'(1) << mdone) : '0;
      expv = pack(eg, CW'(mcnt), ed);
      n_checks++;
      if ({grant, busy, cnt, done} !== expv) begin
        n_errors++;
        $display("FAIL random cyc%0d: got %s want %s", cyc, vec_str({grant, busy, cnt, done}), vec_str(expv));
      end
      n_checks++;
      if (!$onehot0(grant) || !$onehot0(done) || ((grant & done) != '0)) begin
        n_errors++;
        $display("FAIL random_onehot cyc%0d: got g=%b d=%b want one-hot0 and disjoint", cyc, grant, done);
      end
      if (prev_grant == '0 && grant != '0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL random_order cyc%0d: got grant=%b want no new grant", cyc, grant);
        end else begin
          g0 = exp_q.pop_front();
          if (grant !== g0) begin
            n_errors++;
            $display("FAIL random_order cyc%0d: got grant=%b want %b", cyc, grant, g0);
          end
        end
      end
      prev_grant = grant;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL random_leftover: got %0d unmatched grants want 0", exp_q.size());
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset    = 1'b1;
    req      = '0;
    load_val = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_rr_wrap();
    test_abort();
    test_tc_boundary();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cnt_share_arbiter.md
Name: cnt_share_arbiter

Overview:
Round-robin arbiter and sequencer that time-shares one free-running up-counter among NREQ requesters. Each granted requester gets exclusive use of the counter for a programmable number of cycles. It receives a one-cycle done pulse when its count expires. The block sits between requesting control logic and the shared counter datapath; it owns the counter's enable, clear and terminal-count compare.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 8, counter / terminal-count width in bits

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester request level; bit i held high while requester i wants or holds the counter
load_val  input  NREQ*CW  per-requester terminal count; slice i is bits [i*CW +: CW]
grant  output  NREQ  one-hot grant; all-zero when idle
busy  output  1  high while any grant is asserted (OR of grant)
cnt  output  CW  current shared counter value
done  output  NREQ  one-cycle pulse on bit g when grant g expires normally

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, grant=0, busy=0, cnt=0, done=0, tc register=0, rr pointer=0. Outputs reach these values without waiting for a clock edge.
- States: IDLE and RUN. All outputs are registered.
- Default every edge: done=0 unless set below.
- IDLE, when no req bit is set: hold, cnt holds its value.
- IDLE, when any req bit is set: pick the first set bit searching upward from rr pointer, wrapping modulo NREQ; call it g. On that edge:
  - grant=one-hot(g), cnt=0, tc=load_val slice g, rr=(g+1) mod NREQ, state=RUN.
- RUN, normal counting: when req[g]=1 and cnt!=tc, cnt=cnt+1 (no wrap possible since cnt<=tc).
- RUN, expiry: when req[g]=1 and cnt==tc:
  - grant=0, done[g]=1, state=IDLE, cnt holds tc.
- RUN, abort: when req[g]=0 (requester withdrew):
  - grant=0, cnt=0, no done, state=IDLE.
  - Abort wins over expiry on the same edge.
- Timing: grant is high for exactly tc+1 cycles. done is high for the cycle after grant falls. A minimum of one IDLE cycle separates consecutive grants, and that cycle is the done cycle.
- load_val is sampled only at grant; changes during RUN have no effect.
- tc=0: grant is high for 1 cycle, then done.
- tc=2^CW-1: cnt reaches all-ones, then expires; no overflow.
- Requesters drop req on done. A requester still holding req after done is re-arbitrated at lowest priority relative to the new rr pointer.
- Requests arriving during RUN wait; they are not queued beyond the level of req.
- Reset asserted mid-RUN: immediate return to reset values; no done is issued.
- Invariant: grant is one-hot or zero, and done is one-hot or zero. done and grant are never both non-zero for the same bit.

Test Plan:
- Single request: req=0001, load_val[0]=3 after reset release. grant=0001 for 4 cycles with cnt=0,1,2,3; then done=0001 for 1 cycle, grant=0, cnt holds 3.
- Round-robin fairness: req=1111 held continuously, all load_val=1. Grants in order 0001,0010,0100,1000,0001. Each grant lasts 2 cycles with 1 idle/done cycle between.
- Wrap of rr pointer: last grant to requester 3, then req=1001. The next grant goes to 0 before 3.
- Abort: req0 granted with tc=10, req0 drops when cnt=4. Next edge grant=0, cnt=0, done stays 0. A pending req1 is granted after the following edge.
- Boundary tc: tc=0 gives a 1-cycle grant then done. With CW=8 and tc=255, cnt reaches 255 with no wrap and done fires once.
- Async reset mid-RUN: reset low between edges at cnt=5. grant, busy, cnt and done go to 0 immediately. After release with req held, the first grant goes to requester 0.
